hsid_min_max_dist: RTL

Downstream consumer of the squared-difference accumulator. It watches the per-reference final sums, marked by `acc_last`, and tracks the minimum and maximum distance with the reference index that produced each. After a programmable number of references it pulses `done`, giving the classification result for one pixel against the HSI library. The accumulator's output bus connects to this block unmodified.

---
 rtl/hsid_min_max_dist_if.sv | 31 +++
 rtl/hsid_min_max_dist.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hsid_min_max_dist_if.sv
// Shared constants and the accumulator output bus
// consumed by the min/max distance tracker.
package hsid_pkg;
  localparam int HSID_DATA_WIDTH_ACC   = 32;
  localparam int HSID_HSI_LIBRARY_SIZE = 16;
endpackage

interface hsid_min_max_dist_if #(
  parameter int DW = hsid_pkg::HSID_DATA_WIDTH_ACC,
  parameter int AW =
    $clog2(hsid_pkg::HSID_HSI_LIBRARY_SIZE)
);
  logic          acc_valid;
  logic          acc_last;
  logic [AW-1:0] acc_ref;
  logic [DW-1:0] acc_value;

  modport master (
    output acc_valid,
    output acc_last,
    output acc_ref,
    output acc_value
  );

  modport slave (
    input acc_valid,
    input acc_last,
    input acc_ref,
    input acc_value
  );
endinterface

// File: rtl/hsid_min_max_dist.sv
// Tracks min/max final distance and its reference
// index over one pixel's library sweep.
module hsid_min_max_dist
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC,
  parameter int HSI_LIBRARY_SIZE = HSID_HSI_LIBRARY_SIZE,
  parameter int HSI_LIBRARY_SIZE_ADDR =
    $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic [HSI_LIBRARY_SIZE_ADDR:0] lib_size,
  hsid_min_max_dist_if.slave acc,
  output logic busy,
  output logic done,
  output logic error,
  output logic [DATA_WIDTH_ACC-1:0] min_dist,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
  output logic [DATA_WIDTH_ACC-1:0] max_dist,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref
);
  localparam int DW = DATA_WIDTH_ACC;
  localparam int AW = HSI_LIBRARY_SIZE_ADDR;
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_TRACK
  } state_t;

  state_t        r_state, w_state_nx;
  logic [LW-1:0] r_lat, w_lat_nx;
  logic [LW-1:0] r_cnt, w_cnt_nx;
  logic [DW-1:0] r_min, w_min_nx;
  logic [DW-1:0] r_max, w_max_nx;
  logic [AW-1:0] r_min_ref, w_min_ref_nx;
  logic [AW-1:0] r_max_ref, w_max_ref_nx;
  logic          r_done, w_done_nx;
  logic          r_err, w_err_nx;

  logic          w_legal;
  logic          w_ev;
  logic          w_in;
  logic [LW-1:0] w_cnt_inc;

  assign w_legal = (lib_size != '0) &&
    (lib_size <= LW'(HSI_LIBRARY_SIZE));
  assign w_ev = (r_state == S_TRACK) &&
    acc.acc_valid && acc.acc_last;
  assign w_in = {1'b0, acc.acc_ref} < r_lat;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nx   = r_state;
    w_lat_nx     = r_lat;
    w_cnt_nx     = r_cnt;
    w_min_nx     = r_min;
    w_max_nx     = r_max;
    w_min_ref_nx = r_min_ref;
    w_max_ref_nx = r_max_ref;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;
    unique case (1'b1)
      (clear && w_legal): begin
        w_state_nx   = S_TRACK;
        w_lat_nx     = lib_size;
        w_cnt_nx     = '0;
        w_min_nx     = '1;
        w_max_nx     = '0;
        w_min_ref_nx = '0;
        w_max_ref_nx = '0;
      end
      (clear && !w_legal): begin
        w_state_nx = S_IDLE;
        w_err_nx   = 1'b1;
      end
      (!clear && w_ev && w_in): begin
        if (acc.acc_value < r_min) begin
          w_min_nx     = acc.acc_value;
          w_min_ref_nx = acc.acc_ref;
        end
        if (acc.acc_value > r_max) begin
          w_max_nx     = acc.acc_value;
          w_max_ref_nx = acc.acc_ref;
        end
        w_cnt_nx = w_cnt_inc;
        if (w_cnt_inc == r_lat) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      (!clear && w_ev && !w_in): begin
        w_err_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_cnt     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_min_ref <= '0;
      r_max_ref <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lat     <= w_lat_nx;
      r_cnt     <= w_cnt_nx;
      r_min     <= w_min_nx;
      r_max     <= w_max_nx;
      r_min_ref <= w_min_ref_nx;
      r_max_ref <= w_max_ref_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  assign busy     = (r_state == S_TRACK);
  assign done     = r_done;
  assign error    = r_err;
  assign min_dist = r_min;
  assign max_dist = r_max;
  assign min_ref  = r_min_ref;
  assign max_ref  = r_max_ref;
endmodule
